// File: rtl/core_pkg.sv
// Shared definitions for the pipelined core.
// Contents:
//   ADDR_W        - default address width, shared with decode and execute
//   PC_INC        - byte increment between sequential instructions
//   addr_t        - address-width word type
//   fetch_state_t - fetch-stage control states
package core_pkg;

  localparam int ADDR_W = 8;
  localparam int PC_INC = 4;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// Generic pipeline register stage: PC, PC+4 and a valid bit.
// It is written to be reused for later stages such as ID/EX.
// Ports:
//   clk          - clock, rising edge
//   rst          - asynchronous active-low reset; clears all contents
//   en           - load enable; when low, the contents hold
//   flush        - synchronous clear of the valid bit; wins over en
//   pc_in        - PC to capture
//   pcplus4_in   - PC+4 to capture
//   valid_in     - valid bit to capture
//   pc_q         - registered PC
//   pcplus4_q    - registered PC+4
//   valid_q      - registered valid bit (0 = bubble)
module if_id_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [WIDTH-1:0] pcplus4_in,
  input  logic             valid_in,
  output logic [WIDTH-1:0] pc_q,
  output logic [WIDTH-1:0] pcplus4_q,
  output logic             valid_q
);

  // A flush only turns the stage into a bubble.
  // The data fields are left alone because nothing downstream looks at them while valid is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= '0;
      pcplus4_q <= '0;
      valid_q   <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (en) begin
      pc_q      <= pc_in;
      pcplus4_q <= pcplus4_in;
      valid_q   <= valid_in;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage.
// This module owns the program counter and the IF/ID register.
// It applies stall, branch redirect/flush and halt.
// It also keeps a saturating count of instructions passed into IF/ID.
// Ports:
//   clk          - clock, rising edge
//   rst          - asynchronous active-low reset
//   stall        - hold PC and IF/ID
//   PCsrc        - taken branch: redirect to pc_target and flush IF/ID
//   pc_target    - redirect address (low two bits ignored)
//   halt_req     - stop fetching; only reset leaves the halted state
//   PC           - fetch address to instruction memory
//   PC_D         - IF/ID registered PC
//   PCPlus4_D    - IF/ID registered PC+4
//   valid_D      - IF/ID holds a real instruction
//   halted       - stage is in HALT
//   fetch_count  - saturating count of instructions passed into IF/ID
module fetch_stage
  import core_pkg::*;
#(
  parameter int                      ADDRESS_WIDTH = 8,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC     = '0,
  parameter int                      CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     PCsrc,
  input  logic [ADDRESS_WIDTH-1:0] pc_target,
  input  logic                     halt_req,
  output logic [ADDRESS_WIDTH-1:0] PC,
  output logic [ADDRESS_WIDTH-1:0] PC_D,
  output logic [ADDRESS_WIDTH-1:0] PCPlus4_D,
  output logic                     valid_D,
  output logic                     halted,
  output logic [CNT_WIDTH-1:0]     fetch_count
);

  // Instructions are word aligned, so the two low address bits are always cleared.
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ~ADDRESS_WIDTH'(3);
  localparam logic [ADDRESS_WIDTH-1:0] PC_START   = RESET_PC & ALIGN_MASK;

  fetch_state_t state, state_next;

  logic [ADDRESS_WIDTH-1:0] pc_next;
  logic [ADDRESS_WIDTH-1:0] pc_plus4;
  logic                     ifid_en;
  logic                     ifid_flush;
  logic                     count_inc;

  assign pc_plus4 = PC + ADDRESS_WIDTH'(PC_INC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and next-PC selection.
  // Within RUN the priority is: halt, then redirect, then stall, then sequential fetch.
  // A redirect wins over a stall because the instruction held in IF/ID is on the wrong path anyway.
  always_comb begin
    state_next = state;
    pc_next    = PC;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    count_inc  = 1'b0;
    case (state)
      BOOT: begin
        ifid_flush = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        if (halt_req) begin
          ifid_flush = 1'b1;
          state_next = HALT;
        end else if (PCsrc) begin
          ifid_flush = 1'b1;
          pc_next    = pc_target & ALIGN_MASK;
        end else if (!stall) begin
          ifid_en   = 1'b1;
          pc_next   = pc_plus4;
          count_inc = 1'b1;
        end
      end
      HALT: begin
        ifid_flush = 1'b1;
      end
      default: begin
        ifid_flush = 1'b1;
        state_next = HALT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PC <= PC_START;
    end else begin
      PC <= pc_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_count <= '0;
    end else if (count_inc && (fetch_count != '1)) begin
      fetch_count <= fetch_count + CNT_WIDTH'(1);
    end
  end

  assign halted = (state == HALT);

  if_id_reg #(
    .WIDTH(ADDRESS_WIDTH)
  ) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .en         (ifid_en),
    .flush      (ifid_flush),
    .pc_in      (PC),
    .pcplus4_in (pc_plus4),
    .valid_in   (1'b1),
    .pc_q       (PC_D),
    .pcplus4_q  (PCPlus4_D),
    .valid_q    (valid_D)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
// A second instance with a 4-bit counter shares the same stimulus.
// That second instance is used to observe counter saturation.
module tb_fetch_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall;
  logic       PCsrc;
  logic [7:0] pc_target;
  logic       halt_req;

  logic [7:0]  PC, PC_D, PCPlus4_D;
  logic        valid_D, halted;
  logic [15:0] fetch_count;

  logic [7:0] sPC, sPC_D, sPCPlus4_D;
  logic       sValid_D, sHalted;
  logic [3:0] sFetchCount;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .PCsrc       (PCsrc),
    .pc_target   (pc_target),
    .halt_req    (halt_req),
    .PC          (PC),
    .PC_D        (PC_D),
    .PCPlus4_D   (PCPlus4_D),
    .valid_D     (valid_D),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  fetch_stage #(
    .CNT_WIDTH(4)
  ) dutSmall (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .PCsrc       (PCsrc),
    .pc_target   (pc_target),
    .halt_req    (halt_req),
    .PC          (sPC),
    .PC_D        (sPC_D),
    .PCPlus4_D   (sPCPlus4_D),
    .valid_D     (sValid_D),
    .halted      (sHalted),
    .fetch_count (sFetchCount)
  );

  // Compare one observed value against its expected value and count the result.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock edge, then settle away from the edge before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive the control inputs for the next edge.
  task automatic applyStimulus(input logic st, input logic src, input logic [7:0] tgt, input logic hr);
    stall     = st;
    PCsrc     = src;
    pc_target = tgt;
    halt_req  = hr;
  endtask

  // Check the fetch PC and the IF/ID register contents together.
  task automatic checkFetch(input string tag, input logic [7:0] pc, input logic [7:0] pcd,
                            input logic [7:0] p4d, input logic v, input int cnt);
    checkOutput({tag, ".PC"}, 32'(PC), 32'(pc));
    checkOutput({tag, ".PC_D"}, 32'(PC_D), 32'(pcd));
    checkOutput({tag, ".PCPlus4_D"}, 32'(PCPlus4_D), 32'(p4d));
    checkOutput({tag, ".valid_D"}, 32'(valid_D), 32'(v));
    checkOutput({tag, ".count"}, 32'(fetch_count), 32'(cnt));
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    #1;
    checkFetch("reset", 8'h00, 8'h00, 8'h00, 1'b0, 0);
    checkOutput("reset.halted", 32'(halted), 32'd0);
    #1 rst = 1'b1;

    step();
    checkOutput("boot.PC", 32'(PC), 32'h00);
    checkOutput("boot.valid_D", 32'(valid_D), 32'd0);

    step(); checkFetch("run1", 8'h04, 8'h00, 8'h04, 1'b1, 1);
    step(); checkFetch("run2", 8'h08, 8'h04, 8'h08, 1'b1, 2);

    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    step(); step();
    checkFetch("stall", 8'h08, 8'h04, 8'h08, 1'b1, 2);

    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    step(); checkFetch("unstall", 8'h0C, 8'h08, 8'h0C, 1'b1, 3);
    checkOutput("small.count3", 32'(sFetchCount), 32'd3);
    step(); checkFetch("run4", 8'h10, 8'h0C, 8'h10, 1'b1, 4);

    applyStimulus(1'b1, 1'b1, 8'h23, 1'b0);
    step();
    checkOutput("redir.PC", 32'(PC), 32'h20);
    checkOutput("redir.valid_D", 32'(valid_D), 32'd0);
    checkOutput("redir.count", 32'(fetch_count), 32'd4);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    step(); checkFetch("postredir", 8'h24, 8'h20, 8'h24, 1'b1, 5);

    applyStimulus(1'b0, 1'b1, 8'hFE, 1'b0);
    step();
    checkOutput("redirFC.PC", 32'(PC), 32'hFC);
    checkOutput("redirFC.valid_D", 32'(valid_D), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    step(); checkFetch("wrap", 8'h00, 8'hFC, 8'h00, 1'b1, 6);
    step(); checkFetch("run7", 8'h04, 8'h00, 8'h04, 1'b1, 7);

    applyStimulus(1'b0, 1'b1, 8'h40, 1'b1);
    step();
    checkOutput("halt.halted", 32'(halted), 32'd1);
    checkOutput("halt.valid_D", 32'(valid_D), 32'd0);
    checkOutput("halt.PC", 32'(PC), 32'h04);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(i[1], i[0], 8'h80, i[2]);
      step();
      checkOutput("halted.PC", 32'(PC), 32'h04);
    end
    checkOutput("halted.halted", 32'(halted), 32'd1);
    checkOutput("halted.count", 32'(fetch_count), 32'd7);
    checkOutput("halted.valid_D", 32'(valid_D), 32'd0);

    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    #2 rst = 1'b0;
    #1;
    checkFetch("rstHalt", 8'h00, 8'h00, 8'h00, 1'b0, 0);
    checkOutput("rstHalt.halted", 32'(halted), 32'd0);
    checkOutput("rstHalt.smallCount", 32'(sFetchCount), 32'd0);
    #1 rst = 1'b1;

    step();
    checkOutput("boot2.PC", 32'(PC), 32'h00);
    checkOutput("boot2.valid_D", 32'(valid_D), 32'd0);

    repeat (20) step();
    checkFetch("run20", 8'h50, 8'h4C, 8'h50, 1'b1, 20);
    checkOutput("small.sat", 32'(sFetchCount), 32'hF);

    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    step();
    #2 rst = 1'b0;
    #1;
    checkFetch("rstStall", 8'h00, 8'h00, 8'h00, 1'b0, 0);
    checkOutput("rstStall.smallCount", 32'(sFetchCount), 32'd0);
    #1 rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    step();
    checkOutput("boot3.PC", 32'(PC), 32'h00);
    checkOutput("boot3.valid_D", 32'(valid_D), 32'd0);
    step(); checkFetch("run1b", 8'h04, 8'h00, 8'h04, 1'b1, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
